// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the RV32 core's decoder, forwarding unit and
// hazard controller.
//   - 7-bit major opcode constants
//   - hz_state_t: hazard controller FSM states
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;  // loads
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_AUPC = 7'b0010111;  // AUIPC
    localparam logic [6:0] I_TYPE  = 7'b0010011;  // ALU immediate
    localparam logic [6:0] U_TYPE  = 7'b0110111;  // LUI
    localparam logic [6:0] J_TYPE  = 7'b1101111;  // JAL
    localparam logic [6:0] R_TYPE  = 7'b0110011;  // ALU register-register
    localparam logic [6:0] S_TYPE  = 7'b0100011;  // stores
    localparam logic [6:0] B_TYPE  = 7'b1100011;  // conditional branches

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_src_use.sv
// hazard_src_use: reports which source registers an instruction really reads,
// so that a matching rd in a load ahead of it only counts as a hazard when the
// operand is actually consumed.
//   op   in  7  major opcode
//   use1 out 1  instruction reads rs1
//   use2 out 1  instruction reads rs2
module hazard_src_use
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic       use1,
    output logic       use2
);

    always_comb begin
        use1 = 1'b1;
        use2 = 1'b1;
        // LUI, AUIPC and JAL carry no rs1 field at all.
        if (op == U_TYPE || op == OP_AUPC || op == J_TYPE) begin
            use1 = 1'b0;
        end
        // Immediate-form instructions take their second operand from the
        // immediate, so the rs2 bit positions are not a register.
        if (op == I_TYPE || op == U_TYPE || op == OP_AUPC ||
            op == J_TYPE || op == OP_LW  || op == OP_JALR) begin
            use2 = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / NOP-insert controller for the 5-stage RV32 pipeline.
// Covers the hazards forwarding cannot resolve: load-use, taken-branch flush,
// multi-cycle MUL/DIV occupancy of EX and data-memory wait states.
//   clk, rst                  clock, synchronous active-high reset
//   op_s2, src1_s2, src2_s2   opcode / rs1 / rs2 of the ID instruction
//   memRead_s3, rd_s3         EX holds a load, and its rd
//   md_s3                     EX holds a valid MUL/DIV (level)
//   branch_taken_s3           EX resolved a taken branch / JAL / JALR
//   dmem_req_s4, dmem_ready   MEM access request and completion
//   stall_pc, stall_s2..s5    hold PC / register feeding stage N
//   flush_s2..s5              load NOP into register feeding stage N
//   md_busy                   FSM is in MD_WAIT
// All outputs are combinational from state, counter and current inputs.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 34
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_s2,
    input  logic [4:0] src1_s2,
    input  logic [4:0] src2_s2,
    input  logic       memRead_s3,
    input  logic [4:0] rd_s3,
    input  logic       md_s3,
    input  logic       branch_taken_s3,
    input  logic       dmem_req_s4,
    input  logic       dmem_ready,
    output logic       stall_pc,
    output logic       stall_s2,
    output logic       stall_s3,
    output logic       stall_s4,
    output logic       stall_s5,
    output logic       flush_s2,
    output logic       flush_s3,
    output logic       flush_s4,
    output logic       flush_s5,
    output logic       md_busy
);

    // The cycle spent in RUN while md_s3 is first seen counts as one of the
    // MD_CYCLES, and the release cycle (cnt==0) is another, hence the -2.
    localparam bit         MD_MULTI = (MD_CYCLES > 1);
    localparam logic [7:0] MD_LOAD  = MD_MULTI ? 8'(MD_CYCLES - 2) : 8'd0;

    hz_state_t  state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic use1, use2;
    logic mem_wait, md_hold, load_use;

    hazard_src_use u_src_use (
        .op   (op_s2),
        .use1 (use1),
        .use2 (use2)
    );

    assign mem_wait = dmem_req_s4 && !dmem_ready;

    assign md_hold  = (state == RUN && md_s3 && MD_MULTI) ||
                      (state == MD_WAIT && cnt != 8'd0);

    assign load_use = memRead_s3 && (rd_s3 != 5'd0) &&
                      ((use1 && rd_s3 == src1_s2) || (use2 && rd_s3 == src2_s2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                // A frozen pipeline must not start the count: the MUL/DIV
                // only begins its occupancy on an unfrozen cycle.
                if (md_s3 && !mem_wait && MD_MULTI) begin
                    state_nxt = MD_WAIT;
                    cnt_nxt   = MD_LOAD;
                end
            end
            MD_WAIT: begin
                // The unit keeps computing through a memory freeze, so the
                // counter runs on and parks at 0 until the freeze lifts.
                cnt_nxt = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
                if (cnt == 8'd0 && !mem_wait) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stall_pc = 1'b0;
        stall_s2 = 1'b0;
        stall_s3 = 1'b0;
        stall_s4 = 1'b0;
        stall_s5 = 1'b0;
        flush_s2 = 1'b0;
        flush_s3 = 1'b0;
        flush_s4 = 1'b0;
        flush_s5 = 1'b0;
        md_busy  = 1'b0;
        if (!rst) begin
            md_busy = (state == MD_WAIT);
            if (mem_wait) begin
                // Whole front of the pipe freezes; a branch in EX is held too
                // and takes effect on the first unfrozen cycle.
                stall_pc = 1'b1;
                stall_s2 = 1'b1;
                stall_s3 = 1'b1;
                stall_s4 = 1'b1;
                flush_s5 = 1'b1;
            end else if (md_hold) begin
                stall_pc = 1'b1;
                stall_s2 = 1'b1;
                stall_s3 = 1'b1;
                flush_s4 = 1'b1;
            end else if (branch_taken_s3) begin
                // Beats load-use: the dependent ID instruction is killed anyway.
                flush_s2 = 1'b1;
                flush_s3 = 1'b1;
            end else if (load_use) begin
                stall_pc = 1'b1;
                stall_s2 = 1'b1;
                flush_s3 = 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32 core (s1 IF, s2 ID, s3 EX, s4 MEM, s5 WB). It sits beside the forwarding unit and covers every case forwarding cannot resolve:
- load-use hazards
- taken-branch/jump flushes
- multi-cycle MUL/DIV occupancy of EX
- data-memory wait states

It drives hold and NOP-insert controls for the PC and the pipeline registers.

Parameters:
MD_CYCLES, 34, total cycles a MUL/DIV instruction occupies EX (legal range 1..255).

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
op_s2  in  7  opcode of the instruction in ID
src1_s2  in  5  rs1 field in ID
src2_s2  in  5  rs2 field in ID
memRead_s3  in  1  EX holds a load
rd_s3  in  5  rd of the EX instruction
md_s3  in  1  EX holds a valid MUL/DIV instruction (level)
branch_taken_s3  in  1  EX resolved a taken branch, JAL or JALR
dmem_req_s4  in  1  MEM issues a data-memory access
dmem_ready  in  1  data memory completes the access this cycle
stall_pc  out  1  PC holds
stall_s2, stall_s3, stall_s4, stall_s5  out  1 each  hold the pipeline register feeding stage N
flush_s2, flush_s3, flush_s4, flush_s5  out  1 each  load a NOP into the register feeding stage N
md_busy  out  1  FSM is in MD_WAIT

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- While rst is high: all outputs are 0. The next state is RUN and the counter is 0.
- All outputs are combinational from the state, the counter and the current inputs. There is no added latency.

FSM states and counter:
- States: RUN, MD_WAIT.
- Counter cnt is 8 bits.
- RUN -> MD_WAIT when md_s3 && !mem_wait && MD_CYCLES>1. On that transition, load cnt = MD_CYCLES-2.
- In MD_WAIT, cnt decrements each cycle and saturates at 0.
- MD_WAIT -> RUN when cnt==0 && !mem_wait.
- md_s3 is ignored while in MD_WAIT.
- MD_CYCLES==1: the FSM never leaves RUN.

Hazard conditions:
- mem_wait = dmem_req_s4 && !dmem_ready.
- md_hold = (RUN && md_s3 && MD_CYCLES>1) || (MD_WAIT && cnt!=0).
- use1: op_s2 is not LUI (U_type), AUIPC or JAL.
- use2: op_s2 is not I-type ALU, LUI, AUIPC, JAL, LW or JALR.
- load_use = memRead_s3 && rd_s3!=0 && ((use1 && rd_s3==src1_s2) || (use2 && rd_s3==src2_s2)).

Output priority, highest first. Outputs not listed for the active case are 0.
1. mem_wait: stall_pc, stall_s2, stall_s3, stall_s4 = 1; flush_s5 = 1.
2. md_hold: stall_pc, stall_s2, stall_s3 = 1; flush_s4 = 1.
3. branch_taken_s3: flush_s2, flush_s3 = 1. The PC is not stalled; the datapath loads the target.
4. load_use: stall_pc, stall_s2 = 1; flush_s3 = 1. Lasts exactly one cycle; the result is then forwarded from s4/s5.

Boundary and simultaneous cases:
- branch_taken_s3 together with mem_wait: the freeze wins. The branch stays held in EX and takes effect on the first unfrozen cycle.
- branch_taken_s3 together with load_use: the branch wins. No stall; the ID instruction is killed.
- MUL/DIV completes (cnt reaches 0) during mem_wait: stay in MD_WAIT with cnt=0. Release occurs on the first cycle mem_wait is low.
- rst in MD_WAIT: return to RUN on the next edge. The datapath is reset by the same rst.
- md_busy = 1 exactly when the state is MD_WAIT.
- stall and flush are never both asserted for the same register.

Decomposition:
- Shared package riscv_pkg holds:
  - the opcode constants (`OP_LW, `OP_JALR, `OP_AUPC, `I_type, `U_type, `J_type), shared with the forwarding unit and the decoder;
  - the enum typedef hz_state_t {RUN, MD_WAIT}.
- One sub-module: hazard_src_use. It is combinational and computes use1/use2 from the opcode. It is reused by the decoder.
- The FSM and counter stay in hazard_ctrl.

Test Plan:
1. Load-use: memRead_s3=1, rd_s3=5, op_s2=R-type, src2_s2=5, for one cycle -> stall_pc=stall_s2=flush_s3=1 for that cycle only. Repeat with op_s2=I-type ALU, src2_s2=5, src1_s2=0 -> all outputs 0.
2. rd_s3=0: memRead_s3=1, rd_s3=0, src1_s2=0 -> no stall.
3. MUL/DIV with MD_CYCLES=34: md_s3 held high from cycle 0 -> stall_pc/stall_s2/stall_s3/flush_s4=1 for cycles 0..32, all 0 at cycle 33; md_busy=1 for cycles 1..33.
4. Memory wait overlapping MUL/DIV: dmem_req_s4=1, dmem_ready=0 for 3 cycles starting at MUL/DIV cycle 31 -> freeze pattern (stall_s4, flush_s5) on those 3 cycles; release one cycle after dmem_ready=1; cnt holds at 0 meanwhile.
5. Branch plus load-use: branch_taken_s3=1 and load_use true in the same cycle -> flush_s2=flush_s3=1, stall_pc=0.
6. Reset mid-MD_WAIT: rst=1 at cycle 10 of MUL/DIV -> all outputs 0 during rst; md_busy=0 after the edge; a new md_s3 restarts the full 34-cycle count.
